// File: rtl/timeset_ctrl.sv
// timeset_ctrl: time-setting controller for a digital clock.
// Two debounced pushbuttons (MODE, SET) drive a RUN / SET_HOUR / SET_MIN
// state machine. The outputs are single-cycle increment/clear pulses, a
// gated seconds enable and a blink control for the field being edited.

// ---------------------------------------------------------------------------
// timeset_ctrl_debounce: two-flop synchronizer, stable-count debouncer and
// press detector for one active-low pushbutton.
// ---------------------------------------------------------------------------
module timeset_ctrl_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,   // low while the reset-release pipe is still filling
    input  logic i_btn_n,    // raw asynchronous button, 0 = pressed
    output logic o_level_n,  // debounced level, 0 = pressed
    output logic o_press     // one-cycle pulse on debounced released->pressed
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level_n;
    logic          r_level_n_d;
    logic          w_sample_n;

    assign w_sample_n = r_sync[1];

    // Two-flop synchronizer; resets to "released" so no press is invented.
    // NOTE: every sequential block uses non-blocking (<=) so all flops sample
    // the pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else if (i_active) begin
            r_sync <= {r_sync[0], i_btn_n};
        end
    end

    // Debouncer: the level flips only after DEB_CYCLES consecutive samples
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_n <= 1'b1;
            r_cnt     <= '0;
        end else if (i_active) begin
            if (w_sample_n == r_level_n) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_level_n <= w_sample_n;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_n_d <= 1'b1;
        end else if (i_active) begin
            r_level_n_d <= r_level_n;
        end
    end

    assign o_level_n = r_level_n;
    assign o_press   = r_level_n_d & ~r_level_n;

endmodule

// ---------------------------------------------------------------------------
// timeset_ctrl: top level
// ---------------------------------------------------------------------------
module timeset_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int REP_TICKS  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en1hz,
    input  logic       i_btn_mode,
    input  logic       i_btn_set,
    output logic       o_sec_en,
    output logic       o_sec_clr,
    output logic       o_min_inc,
    output logic       o_hour_inc,
    output logic [1:0] o_mode,
    output logic       o_blink
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam int HW = (REP_TICKS > 1) ? $clog2(REP_TICKS + 1) : 1;
    localparam logic [HW-1:0] REP_MAX = HW'(REP_TICKS);

    logic [1:0]    r_rst_pipe;
    logic          w_active;

    state_t        r_state;
    state_t        w_state_next;

    logic [HW-1:0] r_hold;
    logic          r_sec_en;
    logic          r_sec_clr;
    logic          r_min_inc;
    logic          r_hour_inc;
    logic          r_blink;

    logic          w_mode_level_n;
    logic          w_mode_press;
    logic          w_set_level_n;
    logic          w_set_press;

    logic          w_set_state;
    logic          w_state_change;
    logic          w_repeat;
    logic          w_inc_req;
    logic          w_sec_en_next;
    logic          w_sec_clr_next;
    logic          w_min_inc_next;
    logic          w_hour_inc_next;
    logic          w_blink_next;

    // Reset-release pipe: no state moves until two edges after reset rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_pipe <= 2'b00;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b1};
        end
    end

    assign w_active = r_rst_pipe[1];

    timeset_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_active  (w_active),
        .i_btn_n   (i_btn_mode),
        .o_level_n (w_mode_level_n),
        .o_press   (w_mode_press)
    );

    timeset_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_active  (w_active),
        .i_btn_n   (i_btn_set),
        .o_level_n (w_set_level_n),
        .o_press   (w_set_press)
    );

    // Next state and next registered outputs; MODE has priority over SET.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_RUN:      if (w_mode_press) w_state_next = ST_SET_HOUR;
            ST_SET_HOUR: if (w_mode_press) w_state_next = ST_SET_MIN;
            ST_SET_MIN:  if (w_mode_press) w_state_next = ST_RUN;
            default:     w_state_next = ST_RUN;
        endcase

        w_set_state    = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN);
        w_state_change = (w_state_next != r_state);

        // Auto-repeat fires on each tick once the hold counter has saturated.
        w_repeat  = w_set_state && !w_set_level_n && i_en1hz && (r_hold == REP_MAX);
        w_inc_req = w_set_state && !w_mode_press && !w_state_change
                    && (w_set_press || w_repeat);

        w_hour_inc_next = w_inc_req && (r_state == ST_SET_HOUR);
        w_min_inc_next  = w_inc_req && (r_state == ST_SET_MIN);
        w_sec_clr_next  = (r_state == ST_SET_MIN) && w_mode_press;
        w_sec_en_next   = i_en1hz && (r_state == ST_RUN);

        // Blink shows in RUN, restarts shown on entry, toggles per tick.
        w_blink_next = r_blink;
        if (w_state_next == ST_RUN || w_state_change) begin
            w_blink_next = 1'b1;
        end else if (i_en1hz) begin
            w_blink_next = ~r_blink;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else if (w_active) begin
            r_state <= w_state_next;
        end
    end

    // Hold counter: counts ticks while SET is held in a set state, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= '0;
        end else if (w_active) begin
            if (w_set_level_n || !w_set_state || w_state_change) begin
                r_hold <= '0;
            end else if (i_en1hz && (r_hold != REP_MAX)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    // Registered outputs, each driven from a single-cycle next value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sec_en   <= 1'b0;
            r_sec_clr  <= 1'b0;
            r_min_inc  <= 1'b0;
            r_hour_inc <= 1'b0;
            r_blink    <= 1'b1;
        end else if (w_active) begin
            r_sec_en   <= w_sec_en_next;
            r_sec_clr  <= w_sec_clr_next;
            r_min_inc  <= w_min_inc_next;
            r_hour_inc <= w_hour_inc_next;
            r_blink    <= w_blink_next;
        end
    end

    assign o_sec_en   = r_sec_en;
    assign o_sec_clr  = r_sec_clr;
    assign o_min_inc  = r_min_inc;
    assign o_hour_inc = r_hour_inc;
    assign o_mode     = r_state;
    assign o_blink    = r_blink;

endmodule

// File: tb/tb_timeset_ctrl.sv
// tb_timeset_ctrl: directed self-checking bench for timeset_ctrl with
// DEB_CYCLES=4 and REP_TICKS=2.
module tb_timeset_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en1hz    = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_set  = 1'b1;
    logic       o_sec_en;
    logic       o_sec_clr;
    logic       o_min_inc;
    logic       o_hour_inc;
    logic [1:0] o_mode;
    logic       o_blink;

    int checks = 0;
    int errors = 0;

    // Pulse and protocol monitors.
    int n_hour = 0, n_min = 0, n_clr = 0, n_secen = 0, n_tog = 0, n_viol = 0;
    logic p_hour = 1'b0, p_min = 1'b0, p_clr = 1'b0, p_secen = 1'b0, p_blink = 1'b1;
    logic [1:0] p_mode = 2'd0;
    int tog_base;

    always #5 clk = ~clk;

    timeset_ctrl #(.DEB_CYCLES(4), .REP_TICKS(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en1hz    (en1hz),
        .i_btn_mode (btn_mode),
        .i_btn_set  (btn_set),
        .o_sec_en   (o_sec_en),
        .o_sec_clr  (o_sec_clr),
        .o_min_inc  (o_min_inc),
        .o_hour_inc (o_hour_inc),
        .o_mode     (o_mode),
        .o_blink    (o_blink)
    );

    // Count pulses and flag any pulse longer than one cycle, both INCs high
    // together, or a SEC_CLR not coincident with a 2->0 mode change.
    always @(negedge clk) begin
        if (o_hour_inc) n_hour++;
        if (o_min_inc)  n_min++;
        if (o_sec_clr)  n_clr++;
        if (o_sec_en)   n_secen++;
        if (o_blink !== p_blink) n_tog++;
        if ((o_hour_inc && p_hour) || (o_min_inc && p_min) || (o_sec_clr && p_clr) ||
            (o_sec_en && p_secen) || (o_hour_inc && o_min_inc))
            n_viol++;
        if (o_sec_clr && !(o_mode == 2'd0 && p_mode == 2'd2))
            n_viol++;
        p_hour  = o_hour_inc;
        p_min   = o_min_inc;
        p_clr   = o_sec_clr;
        p_secen = o_sec_en;
        p_blink = o_blink;
        p_mode  = o_mode;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode(input int n);
        btn_mode = 1'b0;
        tick(n);
        btn_mode = 1'b1;
        tick(12);
    endtask

    task automatic press_set(input int n);
        btn_set = 1'b0;
        tick(n);
        btn_set = 1'b1;
        tick(12);
    endtask

    task automatic pulse_1hz();
        en1hz = 1'b1;
        tick(1);
        en1hz = 1'b0;
        tick(3);
    endtask

    initial begin
        // Reset values while reset is held.
        tick(3);
        check("rst_mode",     32'(o_mode),     32'd0);
        check("rst_blink",    32'(o_blink),    32'd1);
        check("rst_sec_en",   32'(o_sec_en),   32'd0);
        check("rst_sec_clr",  32'(o_sec_clr),  32'd0);
        check("rst_min_inc",  32'(o_min_inc),  32'd0);
        check("rst_hour_inc", 32'(o_hour_inc), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // A 3-cycle glitch on MODE is shorter than the debounce window.
        press_mode(3);
        check("short_mode_ignored", 32'(o_mode), 32'd0);

        // SEC_EN follows EN1HZ one cycle later in RUN.
        en1hz = 1'b1;
        tick(1);
        check("sec_en_latency", 32'(o_sec_en), 32'd1);
        en1hz = 1'b0;
        tick(1);
        check("sec_en_one_cycle", 32'(o_sec_en), 32'd0);
        repeat (3) pulse_1hz();
        check("sec_en_run_count", 32'(n_secen), 32'd4);

        // SET in RUN is ignored.
        press_set(10);
        check("run_set_hour", 32'(n_hour), 32'd0);
        check("run_set_min",  32'(n_min),  32'd0);

        // RUN -> SET_HOUR, one HOUR_INC per press.
        press_mode(10);
        check("mode_1",        32'(o_mode),  32'd1);
        check("blink_entry_1", 32'(o_blink), 32'd1);
        check("clr_none_0_1",  32'(n_clr),   32'd0);
        press_set(10);
        check("hour_inc_one",  32'(n_hour), 32'd1);
        check("hour_no_min",   32'(n_min),  32'd0);

        // No SEC_EN in set states; four blink toggles end shown.
        repeat (4) pulse_1hz();
        check("sec_en_set_none", 32'(n_secen), 32'd4);
        check("blink_after_4",   32'(o_blink), 32'd1);

        // SET_HOUR -> SET_MIN, one MIN_INC per press.
        press_mode(10);
        check("mode_2",       32'(o_mode), 32'd2);
        check("clr_none_1_2", 32'(n_clr),  32'd0);
        press_set(10);
        check("min_inc_one",  32'(n_min),  32'd1);
        check("min_no_hour",  32'(n_hour), 32'd1);

        // Hold SET across 5 ticks: 1 initial + 3 repeats, 5 blink toggles.
        tog_base = n_tog;
        btn_set = 1'b0;
        tick(10);
        check("hold_initial_min", 32'(n_min), 32'd2);
        repeat (5) pulse_1hz();
        check("hold_repeat_min",  32'(n_min), 32'd5);
        check("hold_blink_tog",   32'(n_tog - tog_base), 32'd5);
        check("hold_blink_level", 32'(o_blink), 32'd0);
        btn_set = 1'b1;
        tick(12);
        check("release_no_more",  32'(n_min), 32'd5);

        // MODE and SET pressed together in SET_MIN: MODE wins, SEC_CLR once.
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        tick(10);
        btn_mode = 1'b1;
        btn_set  = 1'b1;
        tick(12);
        check("simul_mode_0",  32'(o_mode),  32'd0);
        check("simul_no_inc",  32'(n_min),   32'd5);
        check("clr_at_2_0",    32'(n_clr),   32'd1);
        check("blink_run",     32'(o_blink), 32'd1);

        // Reset mid-operation in SET_HOUR with SET held.
        press_mode(10);
        check("mode_1_again", 32'(o_mode), 32'd1);
        btn_set = 1'b0;
        tick(10);
        check("hour_before_rst", 32'(n_hour), 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_mode",     32'(o_mode),     32'd0);
        check("midrst_blink",    32'(o_blink),    32'd1);
        check("midrst_hour_inc", 32'(o_hour_inc), 32'd0);
        check("midrst_min_inc",  32'(o_min_inc),  32'd0);
        check("midrst_sec_en",   32'(o_sec_en),   32'd0);
        check("midrst_sec_clr",  32'(o_sec_clr),  32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check("post_rst_mode", 32'(o_mode), 32'd0);
        check("post_rst_hour", 32'(n_hour), 32'd2);
        btn_set = 1'b1;
        tick(12);

        // MODE held through reset counts as exactly one new press afterwards.
        btn_mode = 1'b0;
        tick(10);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check("held_mode_once", 32'(o_mode), 32'd1);
        btn_mode = 1'b1;
        tick(12);
        check("held_mode_release", 32'(o_mode), 32'd1);

        // Global protocol properties over the whole run.
        check("pulse_violations", 32'(n_viol), 32'd0);
        check("total_sec_clr",    32'(n_clr),  32'd1);
        check("total_hour_inc",   32'(n_hour), 32'd2);
        check("total_min_inc",    32'(n_min),  32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timeset_ctrl.md
TIMESET_CTRL -- requirements
Module: timeset_ctrl

Interface
REQ-001: Parameter DEB_CYCLES, default 500000, SHALL set the debounce stable-sample count (10 ms at 50 MHz).
REQ-002: Parameter REP_TICKS, default 2, SHALL set the number of EN1HZ ticks SET must be held before auto-repeat starts.
REQ-003: CLK  input  1  system clock; all state on rising edge.
REQ-004: RST  input  1  reset, asynchronous, active-low.
REQ-005: EN1HZ  input  1  one-cycle 1 Hz tick from prescaler.
REQ-006: BTN_MODE  input  1  raw mode pushbutton, asynchronous, active-low (0 = pressed).
REQ-007: BTN_SET  input  1  raw set pushbutton, asynchronous, active-low (0 = pressed).
REQ-008: SEC_EN  output  1  gated seconds-counter enable.
REQ-009: SEC_CLR  output  1  one-cycle seconds-counter clear.
REQ-010: MIN_INC  output  1  one-cycle +1 minute pulse to minute counter.
REQ-011: HOUR_INC  output  1  one-cycle +1 hour pulse to hour counter INC input.
REQ-012: MODE  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
REQ-013: BLINK  output  1  display-blank control for selected field (1 = show).

Function
REQ-014: Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-015: Debounced level SHALL change only after DEB_CYCLES consecutive synchronized samples differ from it; any matching sample restarts the count.
REQ-016: A press event SHALL be a single-cycle pulse on the debounced released->pressed transition; release produces no event.
REQ-017: FSM SHALL have states RUN, SET_HOUR, SET_MIN; MODE encoding 2'd3 is unreachable and SHALL return to RUN on the next cycle.
REQ-018: MODE press SHALL advance RUN->SET_HOUR->SET_MIN->RUN, registered, effective the cycle after the event.
REQ-019: On SET_MIN->RUN, SEC_CLR SHALL pulse high for exactly one cycle, coincident with MODE becoming 0.
REQ-020: SET press in SET_HOUR SHALL produce one HOUR_INC pulse the cycle after the event; in SET_MIN one MIN_INC pulse; in RUN it SHALL be ignored.
REQ-021: While SET remains debounced-pressed in a set state, a hold counter SHALL count EN1HZ ticks; after REP_TICKS ticks each further EN1HZ tick SHALL produce one additional INC pulse for the selected field.
REQ-022: Hold counter SHALL clear on SET release, on any state change, and saturate at REP_TICKS.
REQ-023: SEC_EN SHALL equal EN1HZ registered by one cycle when state is RUN, and 0 in set states.
REQ-024: BLINK SHALL be 1 in RUN, set to 1 on entry to any set state, and toggle on every EN1HZ in set states.
REQ-025: Simultaneous MODE and SET events in the same cycle: MODE SHALL win; SET event discarded, no INC pulse.
REQ-026: HOUR_INC and MIN_INC SHALL never be high in the same cycle; no INC pulse in the cycle of a state change.
REQ-027: No output pulse SHALL exceed one cycle regardless of button hold time.

Reset
REQ-028: RST low SHALL asynchronously force: state RUN, MODE=0, BLINK=1, SEC_EN=0, SEC_CLR=0, MIN_INC=0, HOUR_INC=0, debounced levels released, debounce/hold counters 0, synchronizers to 1.
REQ-029: Reset asserted mid-operation (any state, button held) SHALL abort it; after release a still-held button SHALL not generate an event until it has been debounced-released then pressed again... except that a button held through reset SHALL be seen as a new press once debounced, exactly once.
REQ-030: Reset release SHALL be synchronous-safe: first state update no earlier than the second CLK edge after RST rises.

Verification (DEB_CYCLES=4, REP_TICKS=2)
REQ-031: BTN_MODE low 3 cycles then high -> no event, MODE stays 0.
REQ-032: BTN_MODE low 10 cycles, three times -> MODE 0->1->2->0; SEC_CLR one-cycle pulse at 2->0 only.
REQ-033: MODE=1, BTN_SET pressed 10 cycles -> exactly one HOUR_INC; MODE=2 same -> exactly one MIN_INC; MODE=0 same -> none.
REQ-034: MODE=2, BTN_SET held across 5 EN1HZ ticks -> 1 initial MIN_INC plus 3 repeat pulses (ticks 3,4,5); BLINK toggles 5 times.
REQ-035: RUN, 4 EN1HZ pulses -> 4 SEC_EN pulses each 1 cycle later; in MODE=1 -> 0 SEC_EN pulses.
REQ-036: MODE=1 with BTN_SET held, RST pulsed low 1 cycle -> all outputs reset values immediately, MODE=0, no INC pulse afterward.
